// File: rtl/rs_age_select_pkg.sv
// rtl/rs_age_select_pkg.sv - entry type, reset value and circular ROB range test for rs_age_select
package rs_age_select_pkg;
    localparam int RS_PR_W      = 6;
    localparam int RS_ROB_W     = 5;
    localparam int RS_PAYLOAD_W = 64;

    typedef struct packed {
        logic [RS_PR_W-1:0] idx;
        logic               ready;
    } RS_AGE_SRC_t;

    typedef struct packed {
        logic                    valid;
        logic [RS_ROB_W-1:0]     rob;
        logic [RS_PR_W-1:0]      T;
        RS_AGE_SRC_t             T1;
        RS_AGE_SRC_t             T2;
        logic [RS_PAYLOAD_W-1:0] payload;
    } RS_AGE_ENTRY_t;

    localparam RS_AGE_ENTRY_t RS_AGE_ENTRY_RESET = '0;

    // Distances measured from the first squashed index keep the compare correct across wrap.
    function automatic logic rob_in_range(input logic [RS_ROB_W-1:0] rob,
                                          input logic [RS_ROB_W-1:0] first,
                                          input logic [RS_ROB_W-1:0] tail);
        logic [RS_ROB_W-1:0] d_rob;
        logic [RS_ROB_W-1:0] d_tail;
        d_rob  = rob - first;
        d_tail = tail - first;
        return d_rob < d_tail;
    endfunction
endpackage

// File: rtl/rs_age_matrix.sv
// rtl/rs_age_matrix.sv - age matrix, age_q[i][j] set when slot i is older than slot j; grants the oldest requester
module rs_age_matrix
    import rs_age_select_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] alloc_i,
    input  logic [N-1:0] free_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);
    logic [N-1:0] age_q [N];
    logic [N-1:0] age_d [N];
    logic [N-1:0] grant;

    always_comb begin
        age_d = age_q;
        for (int i = 0; i < N; i++) begin
            if (free_i[i] || alloc_i[i]) begin
                age_d[i] = '0;
                for (int j = 0; j < N; j++) age_d[j][i] = 1'b0;
            end
        end
        // Every other slot counts as older than a newcomer; bits left on empty slots never request.
        for (int i = 0; i < N; i++) begin
            if (alloc_i[i]) begin
                for (int j = 0; j < N; j++) begin
                    if (j != i) age_d[j][i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant = req_i;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (req_i[j] && age_q[j][i]) grant[i] = 1'b0;
            end
        end
    end

    assign grant_o = grant;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < N; i++) age_q[i] <= '0;
        end else begin
            age_q <= age_d;
        end
    end
endmodule

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - age-ordered reservation station; define RS_FORWARDING_EN for same-cycle wake-up to issue
// Entry field widths come from rs_age_select_pkg; PR_W/ROB_W/PAYLOAD_W must match the package values.
module rs_age_select
    import rs_age_select_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_CDB     = 2,
    parameter int PR_W        = RS_PR_W,
    parameter int ROB_W       = RS_ROB_W,
    parameter int PAYLOAD_W   = RS_PAYLOAD_W
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               en_i,
    input  logic                               dispatch_valid_i,
    output logic                               dispatch_ready_o,
    input  logic [ROB_W-1:0]                   dispatch_rob_i,
    input  logic [PR_W-1:0]                    dispatch_T_i,
    input  logic [PR_W-1:0]                    dispatch_T1_i,
    input  logic [PR_W-1:0]                    dispatch_T2_i,
    input  logic                               dispatch_T1r_i,
    input  logic                               dispatch_T2r_i,
    input  logic [PAYLOAD_W-1:0]               dispatch_pay_i,
    input  logic [NUM_CDB-1:0]                 cdb_valid_i,
    input  logic [NUM_CDB*PR_W-1:0]            cdb_tag_i,
    output logic                               issue_valid_o,
    input  logic                               issue_ready_i,
    output logic [ROB_W-1:0]                   issue_rob_o,
    output logic [PR_W-1:0]                    issue_T_o,
    output logic [PR_W-1:0]                    issue_T1_o,
    output logic [PR_W-1:0]                    issue_T2_o,
    output logic [PAYLOAD_W-1:0]               issue_pay_o,
    input  logic                               rollback_en_i,
    input  logic [ROB_W-1:0]                   rob_rollback_i,
    input  logic [ROB_W-1:0]                   rob_tail_i,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   free_count_o
);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    RS_AGE_ENTRY_t    ent_q [NUM_ENTRIES];
    RS_AGE_ENTRY_t    ent_d [NUM_ENTRIES];
    logic [CNT_W-1:0] free_count_q, free_count_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    logic [NUM_ENTRIES-1:0] wake1, wake2, squash, req, age_grant, sel_oh, alloc_oh, free_oh;
    logic                   disp_hit1, disp_hit2, dispatch_fire, issue_fire;
    logic [IDX_W-1:0]       sel_idx;

    always_comb begin
        disp_hit1 = 1'b0;
        disp_hit2 = 1'b0;
        wake1     = '0;
        wake2     = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (cdb_valid_i[c]) begin
                if (cdb_tag_i[c*PR_W +: PR_W] == dispatch_T1_i) disp_hit1 = 1'b1;
                if (cdb_tag_i[c*PR_W +: PR_W] == dispatch_T2_i) disp_hit2 = 1'b1;
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (cdb_tag_i[c*PR_W +: PR_W] == ent_q[i].T1.idx) wake1[i] = 1'b1;
                    if (cdb_tag_i[c*PR_W +: PR_W] == ent_q[i].T2.idx) wake2[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        squash = '0;
        req    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            squash[i] = en_i && rollback_en_i && ent_q[i].valid
                        && rob_in_range(ent_q[i].rob, rob_rollback_i, rob_tail_i);
`ifdef RS_FORWARDING_EN
            req[i] = en_i && ent_q[i].valid && !squash[i]
                     && (ent_q[i].T1.ready || wake1[i]) && (ent_q[i].T2.ready || wake2[i]);
`else
            req[i] = en_i && ent_q[i].valid && !squash[i] && ent_q[i].T1.ready && ent_q[i].T2.ready;
`endif
        end
    end

    rs_age_matrix #(.N(NUM_ENTRIES)) u_age (
        .clk_i   (clock_i),
        .reset_i (reset_i),
        .alloc_i (alloc_oh),
        .free_i  (free_oh),
        .req_i   (req),
        .grant_o (age_grant)
    );

    // A stalled issue keeps presenting the same entry even if an older one wakes meanwhile.
    always_comb begin
        sel_oh = age_grant;
        if (lock_q && req[lock_idx_q]) begin
            sel_oh             = '0;
            sel_oh[lock_idx_q] = 1'b1;
        end
        sel_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sel_oh[i]) sel_idx = IDX_W'(i);
        end
    end

    assign issue_valid_o    = |req;
    assign issue_fire       = issue_valid_o && issue_ready_i;
    assign issue_rob_o      = ent_q[sel_idx].rob;
    assign issue_T_o        = ent_q[sel_idx].T;
    assign issue_T1_o       = ent_q[sel_idx].T1.idx;
    assign issue_T2_o       = ent_q[sel_idx].T2.idx;
    assign issue_pay_o      = ent_q[sel_idx].payload;
    assign free_count_o     = free_count_q;
    assign dispatch_ready_o = en_i && !rollback_en_i && (free_count_q != '0);
    assign dispatch_fire    = dispatch_valid_i && dispatch_ready_o;
    assign free_oh          = squash | (issue_fire ? sel_oh : '0);

    always_comb begin
        alloc_oh = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (dispatch_fire && !ent_q[i].valid) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_q[i].valid) begin
                ent_d[i].T1.ready = ent_q[i].T1.ready | wake1[i];
                ent_d[i].T2.ready = ent_q[i].T2.ready | wake2[i];
            end
            if (free_oh[i]) ent_d[i].valid = 1'b0;
            if (alloc_oh[i]) begin
                ent_d[i].valid    = 1'b1;
                ent_d[i].rob      = dispatch_rob_i;
                ent_d[i].T        = dispatch_T_i;
                ent_d[i].T1.idx   = dispatch_T1_i;
                ent_d[i].T1.ready = dispatch_T1r_i | disp_hit1;
                ent_d[i].T2.idx   = dispatch_T2_i;
                ent_d[i].T2.ready = dispatch_T2r_i | disp_hit2;
                ent_d[i].payload  = dispatch_pay_i;
            end
        end
        free_count_d = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!ent_d[i].valid) free_count_d = free_count_d + CNT_W'(1);
        end
        lock_d     = issue_valid_o && !issue_ready_i;
        lock_idx_d = sel_idx;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= RS_AGE_ENTRY_RESET;
            free_count_q <= CNT_W'(NUM_ENTRIES);
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
        end else if (en_i) begin
            ent_q        <= ent_d;
            free_count_q <= free_count_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
        end
    end
endmodule
